ram_sized_access_unit: RTL
==========================

# ram_sized_access_unit

Parametrised successor of the fixed 256-byte RAM behind the memory address and data registers. It adds configurable depth, configurable wait states, selectable endianness, signed/unsigned load extension and alignment aborts. All accesses use the MFA/MFC handshake already driven by the control unit. It sits between MAR/MDR and the control unit, and its read data feeds the MDR input mux directly, so load extension happens here rather than in a separate block.

## Interface
Parameters
- ADDR_W, 8, byte-address width; memory holds 2**ADDR_W bytes; every address is in range.
- WAIT_CYCLES, 2, extra wait states per access; legal range 0..15.
- BIG_ENDIAN, 0, byte order: 0 = little-endian (lowest address is the LSB); 1 = big-endian.

Ports
- CLK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  reset, synchronous and active-high.
- MFA  in  1  memory function activate; held high by the requester until MFC or ABORT.
- RW  in  1  1 = read (load), 0 = write (store).
- DataSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- SGN  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- ADDR  in  ADDR_W  byte address.
- DIN  in  32  store data, right-justified.
- DOUT  out  32  extended load data, registered.
- MFC  out  1  memory function complete.
- ABORT  out  1  request rejected: misaligned address or DataSize 11.
- BUSY  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE, ERR.
- IDLE, MFA=1: latch ADDR, RW, DataSize, SGN and DIN, then choose the next state:
  - ERR if DataSize=11, or halfword with ADDR[0]=1, or word with ADDR[1:0]≠00;
  - otherwise WAIT when WAIT_CYCLES>0, or ACCESS when WAIT_CYCLES=0.
- WAIT: a 4-bit counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Move to ACCESS when the counter reads 0.
- ACCESS: lasts exactly one cycle, then go to DONE.
  - Write: the rising edge that leaves ACCESS commits 1, 2 or 4 bytes at addr, addr+1, … in the selected byte order.
  - Read: the same edge loads DOUT with the assembled value, zero- or sign-extended from bit 7 or bit 15 according to SGN. A word read ignores SGN.
- DONE: MFC=1. Stay while MFA=1; return to IDLE on the edge where MFA=0.
- ERR: ABORT=1. Memory is not modified and DOUT is unchanged. Stay while MFA=1; return to IDLE when MFA=0.
- The latched request is used throughout. Changes on ADDR, DIN, RW or DataSize after the IDLE sampling edge are ignored.
- MFA falling during WAIT or ACCESS does not cancel the access: the write still commits. DONE then lasts exactly one cycle, so MFC is a one-cycle pulse.
- Memory array contents are not affected by CLR; after power-up they are undefined (X in simulation).

## Timing
- Reset values: state IDLE, DOUT=0, MFC=0, ABORT=0, BUSY=0, wait counter 0.
- CLR has priority over everything, including the ACCESS edge. If CLR is high on that edge, no write commits and DOUT is not updated.
- Latency, counting the IDLE edge that samples MFA=1 as edge 0:
  - ACCESS is entered after edge WAIT_CYCLES;
  - MFC goes high after edge WAIT_CYCLES+1 and DOUT is valid in that same cycle;
  - ABORT goes high after edge 0.
- A new request is accepted only in IDLE. At least one MFA=0 cycle separates back-to-back accesses. Minimum access period: WAIT_CYCLES+3 cycles.
- MFC and ABORT are never high together. Neither is ever high while BUSY=0.
- Halfword and word byte addresses never wrap past 2**ADDR_W-1, because alignment guarantees this.

## Test plan
- Reset, then WAIT_CYCLES=2: write word 0x8001_7F02 to 0x10, then read it back → MFC rises after edge 3 of each access, read DOUT=0x8001_7F02. With BIG_ENDIAN=0, byte reads of 0x10..0x13 return 0x02, 0x7F, 0x01, 0x80.
- Sign extension: byte read of 0x13 with SGN=1 → DOUT=0xFFFF_FF80; with SGN=0 → 0x0000_0080. Halfword read of 0x12 with SGN=1 → 0xFFFF_8001.
- Misalignment: word write to 0x11 with DIN=0xDEAD_BEEF → ABORT after edge 0, MFC stays 0; a following word read of 0x10 still returns 0x8001_7F02. DataSize=11 → ABORT.
- BIG_ENDIAN=1, WAIT_CYCLES=0: word write 0x1122_3344 to 0x20, then byte read of 0x20 → DOUT=0x11, MFC after edge 1.
- CLR asserted on the ACCESS edge of a write of 0x5555_5555 to 0x10 → FSM returns to IDLE, all outputs are at reset values, and a later read of 0x10 returns the old contents.
- MFA dropped during WAIT of a byte write of 0xAA to 0x30 → the write still commits, MFC is high for exactly one cycle, and a read of 0x30 returns 0xAA.

Source files
------------

// File: rtl/ram_sized_access_unit.sv
// Byte-addressed RAM with sized, aligned loads/stores over the MFA/MFC handshake.
// Configurable wait states and byte order; loads are extended before driving DOUT.
module ram_sized_access_unit #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2,
    parameter bit BIG_ENDIAN  = 1'b0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        DataSize,
    input  logic              SGN,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DIN,
    output logic [31:0]       DOUT,
    output logic              MFC,
    output logic              ABORT,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                rw_q;
    logic [1:0]          size_q;
    logic                sgn_q;
    logic [31:0]         din_q;
    logic [31:0]         dout_q;
    logic [31:0]         rd_raw;
    logic                wr_en;
    logic [7:0]          mem_q [2**ADDR_W];

    function automatic logic req_bad(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Which byte of the right-justified value lives at memory offset i.
    function automatic int lane_of(input int i, input int n);
        return BIG_ENDIAN ? (n - 1 - i) : i;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] sz,
                                                input logic sgn);
        case (sz)
            2'b00:   return {{24{sgn & raw[7]}}, raw[7:0]};
            2'b01:   return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (MFA) begin
                    if (req_bad(DataSize, ADDR[1:0])) begin
                        state_d = S_ERR;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   if (!MFA) state_d = S_IDLE;
            S_ERR:    if (!MFA) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        MFC   = (state_q == S_DONE);
        ABORT = (state_q == S_ERR);
        BUSY  = (state_q != S_IDLE);
    end

    // Request is captured once in IDLE; later bus activity is ignored.
    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && MFA) begin
            addr_q <= ADDR;
            rw_q   <= RW;
            size_q <= DataSize;
            sgn_q  <= SGN;
            din_q  <= DIN;
        end
    end

    always_comb begin
        rd_raw = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < size_bytes(size_q)) begin
                rd_raw[8*lane_of(i, size_bytes(size_q)) +: 8] = mem_q[addr_q | ADDR_W'(i)];
            end
        end
    end

    assign wr_en = (state_q == S_ACCESS) && !rw_q && !CLR;

    // Alignment guarantees OR-ing the offset equals adding it.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i < size_bytes(size_q)) begin
                    mem_q[addr_q | ADDR_W'(i)] <= din_q[8*lane_of(i, size_bytes(size_q)) +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            dout_q <= 32'd0;
        end else if (state_q == S_ACCESS && rw_q) begin
            dout_q <= load_extend(rd_raw, size_q, sgn_q);
        end
    end

    assign DOUT = dout_q;

endmodule
